// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store.
// Optional build macro ARB_PERF_CNT_EN adds saturating conflict and fetch-stall counters.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_strb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         conflict_cnt,
    output logic [31:0]         fetch_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_D
    } tag_t;

    tag_t             tag_q, tag_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             force_if;

    // NOTE: every output and next-state value gets a default first, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        tag_d     = TAG_NONE;
        starve_d  = '0;
        force_if  = if_req && (starve_q == STARVE_LIM);

        if (!rst) begin
            // Data wins unless fetch has been denied STARVE_MAX cycles in a row.
            if (d_req && !force_if) begin
                d_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = d_addr;
                if (d_we) begin
                    mem_we    = d_strb;
                    mem_wdata = d_wdata;
                end else begin
                    tag_d = TAG_D;
                end
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
                tag_d    = TAG_IF;
            end

            if (if_req && !if_gnt)
                starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;

            // Response for last cycle's read, steered by the registered owner tag.
            if_rvalid = (tag_q == TAG_IF);
            d_rvalid  = (tag_q == TAG_D);
            if_rdata  = if_rvalid ? mem_rdata : '0;
            d_rdata   = d_rvalid  ? mem_rdata : '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= TAG_NONE;
            starve_q <= '0;
        end else begin
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt    <= '0;
            fetch_stall_cnt <= '0;
        end else begin
            if (if_req && d_req && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 32'd1;
            if (if_req && !if_gnt && (fetch_stall_cnt != '1))
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model with its own memory image.
module tb_imem_dmem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_strb;
    logic [15:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
    logic [31:0] fetch_stall_cnt;
`endif

    int vectors;
    int miscompares;

    logic [63:0] sram    [0:8191];
    logic [63:0] ref_mem [0:8191];

    imem_dmem_arbiter #(.ADDR_W(16), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .conflict_cnt(conflict_cnt), .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous SRAM with byte write enables.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 8'h00)
                mem_rdata <= sram[mem_addr[15:3]];
            else
                for (int b = 0; b < 8; b++)
                    if (mem_we[b]) sram[mem_addr[15:3]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    task automatic drive(input logic r, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic dwe, input logic [7:0] ds,
                         input logic [15:0] da, input logic [63:0] dw);
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_strb = ds; d_addr = da; d_wdata = dw;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
    endtask

    task automatic preload(input logic [15:0] a, input logic [63:0] w);
        sram[a[15:3]]    = w;
        ref_mem[a[15:3]] = w;
    endtask

    task automatic test_reset();
        preload(16'h0000, 64'h00000013_00000093);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
            vectors++;
            if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 13'h0 ||
                if_rdata !== 64'h0 || d_rdata !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_outputs: gnt/en/we/rv=%b rdata=%h/%h required all 0",
                         {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}, if_rdata, d_rdata);
            end
        end
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        vectors++;
        if ({if_gnt, d_gnt, mem_en} !== 3'b101 || mem_addr !== 16'h0 || mem_we !== 8'h0) begin
            miscompares++;
            $display("FAIL first_fetch_gnt: if/d/en=%b addr=%h we=%h required 101 0000 00",
                     {if_gnt, d_gnt, mem_en}, mem_addr, mem_we);
        end
        idle();
        vectors++;
        if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 64'h00000013_00000093) begin
            miscompares++;
            $display("FAIL first_fetch_data: rv=%b/%b data=%h required 1/0 0000001300000093",
                     if_rvalid, d_rvalid, if_rdata);
        end
        idle();
        vectors++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_rvalid: rv=%b required 00", {if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_simultaneous();
        preload(16'h9000, 64'h0000_0000_DEAD_BEEF);
        drive(1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b01 || mem_addr !== 16'h9000 || mem_we !== 8'h0) begin
            miscompares++;
            $display("FAIL simul_gnt: if/d=%b addr=%h we=%h required 01 9000 00",
                     {if_gnt, d_gnt}, mem_addr, mem_we);
        end
        idle();
        vectors++;
        if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 64'hDEADBEEF || if_rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL simul_rdata: rv=%b d_rdata=%h if_rdata=%h required 01 deadbeef 0",
                     {if_rvalid, d_rvalid}, d_rdata, if_rdata);
        end
    endtask

    task automatic test_starvation();
        logic prev_if;
        logic exp_if;
        prev_if = 1'b0;
        idle();
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
            exp_if = (k % (STARVE_MAX + 1)) == STARVE_MAX;
            vectors++;
            if ({if_gnt, d_gnt} !== {exp_if, !exp_if}) begin
                miscompares++;
                $display("FAIL starve_gnt[%0d]: if/d=%b required %b", k, {if_gnt, d_gnt},
                         {exp_if, !exp_if});
            end
            if (k > 0) begin
                vectors++;
                if ({if_rvalid, d_rvalid} !== {prev_if, !prev_if}) begin
                    miscompares++;
                    $display("FAIL starve_rvalid[%0d]: rv=%b required %b", k,
                             {if_rvalid, d_rvalid}, {prev_if, !prev_if});
                end
            end
            prev_if = exp_if;
        end
        idle();
    endtask

    task automatic test_store_load();
        preload(16'hfff8, 64'h11223344_55667788);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'hF0, 16'hfff8, 64'h000000FF_00000000);
        vectors++;
        if (d_gnt !== 1'b1 || mem_we !== 8'hF0 || mem_wdata !== 64'h000000FF_00000000 ||
            mem_addr !== 16'hfff8) begin
            miscompares++;
            $display("FAIL store_drive: gnt=%b we=%h wdata=%h addr=%h required 1 f0 000000ff00000000 fff8",
                     d_gnt, mem_we, mem_wdata, mem_addr);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h00, 16'hfff8, 64'h0);
        vectors++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL store_no_rvalid: rvalid=%b gnt=%b required 0 1", d_rvalid, d_gnt);
        end
        idle();
        vectors++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h000000FF_55667788) begin
            miscompares++;
            $display("FAIL load_after_store: rvalid=%b data=%h required 1 000000ff55667788",
                     d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        // Build up fetch starvation, then reset while a load response is pending.
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
        drive(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
        vectors++;
        if (d_rvalid !== 1'b0 || d_rdata !== 64'h0 || d_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drops_read: rvalid=%b rdata=%h gnt=%b required 0 0 0",
                     d_rvalid, d_rdata, d_gnt);
        end
        idle();
        vectors++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL tag_cleared: rv=%b required 00", {if_rvalid, d_rvalid});
        end
        for (int k = 0; k <= STARVE_MAX; k++) begin
            drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
            vectors++;
            if (if_gnt !== (k == STARVE_MAX)) begin
                miscompares++;
                $display("FAIL starve_cleared[%0d]: if_gnt=%b required %b", k, if_gnt,
                         k == STARVE_MAX);
            end
        end
        idle();
    endtask

    task automatic test_random();
        int          streak;
        logic        p_if, p_d;
        logic [63:0] p_data;
        logic        r, ir, dr, dwe, e_i, e_d;
        logic [15:0] ia, da;
        logic [7:0]  ds;
        logic [63:0] dw, w;
        do_reset();
        streak = 0; p_if = 1'b0; p_d = 1'b0; p_data = 64'h0;
        for (int n = 0; n < 2000; n++) begin
            r   = ($urandom_range(0, 49) == 0);
            ir  = ($urandom_range(0, 9) < 7);
            dr  = ($urandom_range(0, 9) < 7);
            dwe = $urandom_range(0, 1) == 1;
            ds  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ia  = 16'h0100 + 16'($urandom_range(0, 7) * 8);
            da  = 16'h0100 + 16'($urandom_range(0, 7) * 8);
            dw  = {$urandom, $urandom};

            e_d = !r && dr && !(ir && streak >= STARVE_MAX);
            e_i = !r && ir && !e_d;
            if (r) begin p_if = 1'b0; p_d = 1'b0; end

            drive(r, ir, ia, dr, dwe, ds, da, dw);
            vectors++;
            if ({if_gnt, d_gnt, mem_en} !== {e_i, e_d, e_i | e_d}) begin
                miscompares++;
                $display("FAIL rand_gnt[%0d]: if/d/en=%b required %b", n,
                         {if_gnt, d_gnt, mem_en}, {e_i, e_d, e_i | e_d});
            end
            if (e_i || e_d) begin
                vectors++;
                if (mem_addr !== (e_d ? da : ia) || mem_we !== ((e_d && dwe) ? ds : 8'h00) ||
                    ((e_d && dwe) && mem_wdata !== dw)) begin
                    miscompares++;
                    $display("FAIL rand_mem[%0d]: addr=%h we=%h wdata=%h required %h %h %h", n,
                             mem_addr, mem_we, mem_wdata, e_d ? da : ia,
                             (e_d && dwe) ? ds : 8'h00, dw);
                end
            end
            vectors++;
            if ({if_rvalid, d_rvalid} !== {p_if, p_d} ||
                if_rdata !== (p_if ? p_data : 64'h0) || d_rdata !== (p_d ? p_data : 64'h0)) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: rv=%b if=%h d=%h required %b data %h", n,
                         {if_rvalid, d_rvalid}, if_rdata, d_rdata, {p_if, p_d}, p_data);
            end

            if (r)
                streak = 0;
            else if (ir && !e_i)
                streak = (streak < STARVE_MAX) ? streak + 1 : streak;
            else
                streak = 0;
            p_if = e_i;
            p_d  = e_d && !dwe;
            p_data = ref_mem[(e_d ? da : ia) >> 3];
            if (e_d && dwe) begin
                w = ref_mem[da >> 3];
                for (int b = 0; b < 8; b++)
                    if (ds[b]) w[8*b +: 8] = dw[8*b +: 8];
                ref_mem[da >> 3] = w;
            end
        end
        idle();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        idle();
        vectors++;
        if (conflict_cnt !== 32'd0 || fetch_stall_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_reset: conflict=%0d stall=%0d required 0 0",
                     conflict_cnt, fetch_stall_cnt);
        end
        for (int k = 0; k < 10; k++)
            drive(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 8'h0, 16'h9000, 64'h0);
        idle();
        vectors++;
        if (conflict_cnt !== 32'd10 || fetch_stall_cnt !== 32'd8) begin
            miscompares++;
            $display("FAIL perf_counts: conflict=%0d stall=%0d required 10 8",
                     conflict_cnt, fetch_stall_cnt);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_strb = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 8192; i++) begin
            sram[i]    = {$urandom, $urandom};
            ref_mem[i] = sram[i];
        end

        test_reset();
        test_simultaneous();
        test_starvation();
        test_store_load();
        test_reset_mid_read();
        test_random();
`ifdef ARB_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters: the core's instruction-fetch port and its load/store port.
- Lets the core run from a unified memory image (program plus data, with completion flag at 0xfffc) instead of separate im/dm arrays.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.
- Read data returns one cycle after grant, routed back by a registered owner tag.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 64, data width; must be a multiple of 8.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced a grant; must be >= 1.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; addr held stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; fields held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_strb  in  DATA_W/8  byte-write strobes (store only)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid (cycle after d_gnt, loads only)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  SRAM access enable
- mem_we  out  DATA_W/8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: while rst=1, all outputs are forced low.
  - Covers if_gnt, d_gnt, mem_en, mem_we, if_rvalid and d_rvalid.
  - owner tag resets to NONE and starve_cnt resets to 0.
  - rdata outputs are 0.
- Arbitration is combinational within a cycle; at most one grant per cycle.
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both requests with starve_cnt < STARVE_MAX: d_gnt=1.
  - Both requests with starve_cnt == STARVE_MAX: if_gnt=1.
  - Neither request: no grant, mem_en=0.
- SRAM drive on a granted cycle: mem_en=1, mem_addr = the granted address.
  - Store: mem_we=d_strb, mem_wdata=d_wdata.
  - Load or fetch: mem_we=0.
- starve_cnt update (registered):
  - Increment when if_req=1 and if_gnt=0.
  - Clear when if_gnt=1 or if_req=0.
  - Saturate at STARVE_MAX.
- owner tag (registered): IF, D or NONE.
  - Set to IF on a fetch grant and to D on a load grant.
  - Set to NONE on a store grant or an idle cycle.
- Response cycle N+1:
  - if_rvalid = (tag==IF).
  - d_rvalid = (tag==D).
  - The matching rdata = mem_rdata; the other rdata holds 0.
- Latency: fixed at 1 cycle from grant to rvalid. Back-to-back grants are allowed every cycle, giving full throughput.
- A store with d_strb=0 is granted, drives mem_en=1 and mem_we=0, and produces no rvalid.
- A requester that drops req before gnt is legal. No state is retained for it beyond starve_cnt clearing.
- Reset asserted while a read is pending drops the response: no rvalid in the following cycle.
- Same-address store then fetch in consecutive cycles: the fetch sees the new data (SRAM write-then-read ordering). No bypass is needed inside the arbiter.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs conflict_cnt (32) and fetch_stall_cnt (32), both reset to 0 and saturating at 0xFFFFFFFF.
  - conflict_cnt increments on each cycle with if_req && d_req.
  - fetch_stall_cnt increments on each cycle with if_req && !if_gnt.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then fetch-only:
  - Stimulus: hold rst=1 for 2 cycles with if_req=1, then release. Fetch if_addr=0x0000, SRAM word=0x00000013_00000093.
  - Response: no gnt or rvalid during reset. if_gnt in the first cycle after release; if_rvalid=1 with that data one cycle later.
- Simultaneous requests:
  - Stimulus: if_req and d_req (load, 0x9000, word=0x0000_0000_DEAD_BEEF) asserted together.
  - Response: d_gnt=1 and if_gnt=0. Next cycle d_rvalid=1, d_rdata=0xDEADBEEF, if_rvalid=0.
- Starvation guard:
  - Stimulus: STARVE_MAX=4, d_req held high continuously with loads, if_req held high.
  - Response: d_gnt for 4 cycles, if_gnt in the 5th cycle, then d_gnt resumes. Repeats every 5 cycles.
- Store then load:
  - Stimulus: store d_addr=0xfff8, d_strb=0xF0, d_wdata=0x000000FF_00000000, then a load at 0xfff8.
  - Response: store produces no d_rvalid. The load returns 0xFF in bytes 4-7; bytes 0-3 keep their prior value.
- Reset mid-read:
  - Stimulus: load granted in cycle N, rst=1 in cycle N+1.
  - Response: d_rvalid=0 in N+1, tag=NONE, starve_cnt=0.
- ARB_PERF_CNT_EN build:
  - Stimulus: 10 cycles of both reqs with STARVE_MAX=4.
  - Response: conflict_cnt=10, fetch_stall_cnt=8.
